// File: rtl/ysyx_22041405_idu_stage.sv
// RV32I integer-ALU decode stage: decodes OP/OP-IMM/LUI into the EXU control
// bundle and holds it in a one-entry valid/ready pipeline register.
module ysyx_22041405_idu_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic             rf_wen,
  output logic [WIDTH-1:0] Imm,
  output logic [7:0]       alu_opcode,
  output logic             alu_src2_sel,
  output logic             alu_add_or_sub,
  output logic             alu_U_or_S,
  output logic             illegal
);

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  logic [7:0]       f3_onehot;
  logic             dec_ill, dec_src2, dec_sub, dec_us, dec_wen;
  logic [7:0]       dec_op;
  logic [WIDTH-1:0] dec_imm;
  logic [4:0]       dec_rs1, dec_rs2, dec_rd;

  // slt and sltu share one ALU lane; signedness comes from alu_U_or_S
  always_comb begin
    f3_onehot = 8'h00;
    case (funct3)
      3'b000: f3_onehot = 8'h01;
      3'b001: f3_onehot = 8'h02;
      3'b010: f3_onehot = 8'h04;
      3'b011: f3_onehot = 8'h04;
      3'b100: f3_onehot = 8'h08;
      3'b101: f3_onehot = 8'h10;
      3'b110: f3_onehot = 8'h20;
      3'b111: f3_onehot = 8'h40;
      default: f3_onehot = 8'h00;
    endcase
  end

  always_comb begin
    dec_ill  = 1'b0;
    dec_op   = 8'h00;
    dec_src2 = 1'b0;
    dec_sub  = 1'b0;
    dec_us   = 1'b0;
    dec_imm  = '0;
    dec_rs1  = 5'd0;
    dec_rs2  = 5'd0;
    dec_rd   = 5'd0;
    dec_wen  = 1'b0;
    case (opcode)
      OPC_OPIMM: begin
        dec_src2 = 1'b1;
        dec_rs1  = in_inst[19:15];
        dec_rd   = in_inst[11:7];
        dec_op   = f3_onehot;
        dec_imm  = {{(WIDTH-12){in_inst[31]}}, in_inst[31:20]};
        dec_us   = (funct3 == 3'b011);
        if (funct3 == 3'b001) begin
          dec_imm = {{(WIDTH-5){1'b0}}, in_inst[24:20]};
          dec_ill = (funct7 != F7_ZERO);
        end
        if (funct3 == 3'b101) begin
          dec_imm = {{(WIDTH-5){1'b0}}, in_inst[24:20]};
          dec_us  = (funct7 == F7_ZERO);
          dec_ill = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
        end
      end
      OPC_OP: begin
        dec_rs1 = in_inst[19:15];
        dec_rs2 = in_inst[24:20];
        dec_rd  = in_inst[11:7];
        dec_op  = f3_onehot;
        dec_us  = (funct3 == 3'b011) || ((funct3 == 3'b101) && (funct7 == F7_ZERO));
        dec_sub = (funct7 == F7_ALT) && (funct3 == 3'b000);
        dec_ill = ((funct7 != F7_ZERO) && (funct7 != F7_ALT)) ||
                  ((funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101));
      end
      OPC_LUI: begin
        dec_op   = 8'h80;
        dec_src2 = 1'b1;
        dec_rd   = in_inst[11:7];
        dec_imm  = {in_inst[31:12], 12'h000};
      end
      default: dec_ill = 1'b1;
    endcase
    // an illegal instruction carries no controls at all, only the flag
    if (dec_ill) begin
      dec_op   = 8'h00;
      dec_src2 = 1'b0;
      dec_sub  = 1'b0;
      dec_us   = 1'b0;
      dec_imm  = '0;
      dec_rs1  = 5'd0;
      dec_rs2  = 5'd0;
      dec_rd   = 5'd0;
    end
    dec_wen = !dec_ill && (dec_rd != 5'd0);
  end

  logic             valid_q;
  logic [WIDTH-1:0] pc_q, imm_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic             wen_q, src2_q, sub_q, us_q, ill_q;
  logic [7:0]       op_q;
  logic             accept;

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      rd_q    <= 5'd0;
      wen_q   <= 1'b0;
      src2_q  <= 1'b0;
      sub_q   <= 1'b0;
      us_q    <= 1'b0;
      ill_q   <= 1'b0;
      op_q    <= 8'h00;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pc_q    <= in_pc;
      imm_q   <= dec_imm;
      rs1_q   <= dec_rs1;
      rs2_q   <= dec_rs2;
      rd_q    <= dec_rd;
      wen_q   <= dec_wen;
      src2_q  <= dec_src2;
      sub_q   <= dec_sub;
      us_q    <= dec_us;
      ill_q   <= dec_ill;
      op_q    <= dec_op;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign rs1_addr       = rs1_q;
  assign rs2_addr       = rs2_q;
  assign rd_addr        = rd_q;
  assign rf_wen         = wen_q;
  assign Imm            = imm_q;
  assign alu_opcode     = op_q;
  assign alu_src2_sel   = src2_q;
  assign alu_add_or_sub = sub_q;
  assign alu_U_or_S     = us_q;
  assign illegal        = ill_q;

endmodule

// File: tb/tb_ysyx_22041405_idu_stage.sv
// Directed bench for the decode stage: expected bundles are queued on accept
// and compared against the registered outputs while held and when consumed.
module tb_ysyx_22041405_idu_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] imm;
    logic [7:0]  op;
    logic        src2;
    logic        sub;
    logic        us;
    logic        ill;
  } exp_t;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, Imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rf_wen, alu_src2_sel, alu_add_or_sub, alu_U_or_S, illegal;
  logic [7:0]  alu_opcode;

  ysyx_22041405_idu_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rf_wen(rf_wen), .Imm(Imm), .alu_opcode(alu_opcode),
    .alu_src2_sel(alu_src2_sel), .alu_add_or_sub(alu_add_or_sub),
    .alu_U_or_S(alu_U_or_S), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t q[$];
  logic mvalid = 1'b0;

  function automatic exp_t obs();
    exp_t o;
    o.pc = out_pc; o.rs1 = rs1_addr; o.rs2 = rs2_addr; o.rd = rd_addr;
    o.wen = rf_wen; o.imm = Imm; o.op = alu_opcode; o.src2 = alu_src2_sel;
    o.sub = alu_add_or_sub; o.us = alu_U_or_S; o.ill = illegal;
    return o;
  endfunction

  // fields: rs1 rs2 rd wen imm op src2 sub us ill (pc filled in at drive time)
  function automatic exp_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic wen,
                              input logic [31:0] imm, input logic [7:0] op,
                              input logic src2, input logic sub,
                              input logic us, input logic ill);
    exp_t e;
    e.pc = 32'h0; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.wen = wen;
    e.imm = imm; e.op = op; e.src2 = src2; e.sub = sub; e.us = us; e.ill = ill;
    return e;
  endfunction

  task automatic step(input string tag, input logic v, input logic [31:0] inst,
                      input logic [31:0] pc, input logic ordy, input logic fl,
                      input exp_t e);
    exp_t   ee;
    logic   exp_rdy;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl && (!mvalid || ordy);
    n_assert++;
    assert (in_ready === exp_rdy) else begin
      n_fail++;
      $error("FAIL %s in_ready obs=%b exp=%b", tag, in_ready, exp_rdy);
    end
    n_assert++;
    assert (out_valid === mvalid) else begin
      n_fail++;
      $error("FAIL %s out_valid obs=%b exp=%b", tag, out_valid, mvalid);
    end
    if (mvalid && q.size() > 0) begin
      n_assert++;
      assert (obs() === q[0]) else begin
        n_fail++;
        $error("FAIL %s bundle obs=%h exp=%h", tag, obs(), q[0]);
      end
    end
    if (mvalid && (ordy || fl)) begin
      void'(q.pop_front());
      mvalid = 1'b0;
    end
    if (v && exp_rdy) begin
      ee = e;
      ee.pc = pc;
      q.push_back(ee);
      mvalid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  exp_t E_ADDI, E_SUB, E_SRAI, E_LUI, E_SRLI, E_SLTU, E_ECALL, E_NOP, E_NEG,
        E_ILLOP, E_AND, E_NONE;

  initial begin
    E_ADDI  = mk(5'd0, 5'd0,  5'd1, 1'b1, 32'd5,        8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    E_SUB   = mk(5'd1, 5'd2,  5'd3, 1'b1, 32'd0,        8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    E_SRAI  = mk(5'd5, 5'd0,  5'd5, 1'b1, 32'd3,        8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    E_LUI   = mk(5'd0, 5'd0,  5'd7, 1'b1, 32'h12345000, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    E_SRLI  = mk(5'd6, 5'd0,  5'd6, 1'b1, 32'd4,        8'h10, 1'b1, 1'b0, 1'b1, 1'b0);
    E_SLTU  = mk(5'd9, 5'd10, 5'd8, 1'b1, 32'd0,        8'h04, 1'b0, 1'b0, 1'b1, 1'b0);
    E_ECALL = mk(5'd0, 5'd0,  5'd0, 1'b0, 32'd0,        8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    E_NOP   = mk(5'd0, 5'd0,  5'd0, 1'b0, 32'd0,        8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    E_NEG   = mk(5'd2, 5'd0,  5'd2, 1'b1, 32'hFFFFFFFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    E_ILLOP = mk(5'd0, 5'd0,  5'd0, 1'b0, 32'd0,        8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    E_AND   = mk(5'd5, 5'd6,  5'd4, 1'b1, 32'd0,        8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    E_NONE  = '0;

    rst = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0;
    out_ready = 1'b0; flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_assert++;
    assert (obs() === E_NONE && out_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL reset_state obs=%h/%b exp=%h/0", obs(), out_valid, E_NONE);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_assert++;
    assert (in_ready === 1'b1) else begin
      n_fail++;
      $error("FAIL reset_ready obs=%b exp=1", in_ready);
    end

    // back-to-back stream
    step("addi", 1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, E_ADDI);
    step("sub",  1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0, E_SUB);
    step("srai", 1'b1, 32'h4032D293, 32'h108, 1'b1, 1'b0, E_SRAI);
    step("lui",  1'b1, 32'h123453B7, 32'h10C, 1'b1, 1'b0, E_LUI);
    // backpressure on the held lui with srli offered
    step("bp0",  1'b1, 32'h00435313, 32'h110, 1'b0, 1'b0, E_SRLI);
    step("bp1",  1'b1, 32'h00435313, 32'h110, 1'b0, 1'b0, E_SRLI);
    step("bp2",  1'b1, 32'h00435313, 32'h110, 1'b0, 1'b0, E_SRLI);
    step("srli", 1'b1, 32'h00435313, 32'h110, 1'b1, 1'b0, E_SRLI);
    step("sltu", 1'b1, 32'h00A4B433, 32'h114, 1'b1, 1'b0, E_SLTU);
    step("ecall",1'b1, 32'h00000073, 32'h118, 1'b1, 1'b0, E_ECALL);
    step("nop",  1'b1, 32'h00000013, 32'h11C, 1'b1, 1'b0, E_NOP);
    step("neg",  1'b1, 32'hFFF10113, 32'h120, 1'b1, 1'b0, E_NEG);
    step("illop",1'b1, 32'h40209033, 32'h124, 1'b1, 1'b0, E_ILLOP);
    step("and",  1'b1, 32'h0062F233, 32'h128, 1'b1, 1'b0, E_AND);
    step("idle", 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, E_NONE);
    // flush the held and bundle while a new one is offered
    step("flush",1'b1, 32'h00500093, 32'h12C, 1'b1, 1'b1, E_ADDI);
    step("post_flush", 1'b0, 32'h0,  32'h0,   1'b1, 1'b0, E_NONE);
    // async reset while holding a bundle
    step("pre_rst", 1'b1, 32'h123453B7, 32'h130, 1'b0, 1'b0, E_LUI);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_assert++;
    assert (obs() === E_NONE && out_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL async_reset obs=%h/%b exp=%h/0", obs(), out_valid, E_NONE);
    end
    q.delete();
    mvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst_sub", 1'b1, 32'h402081B3, 32'h200, 1'b1, 1'b0, E_SUB);
    step("drain",        1'b0, 32'h0,        32'h0,   1'b1, 1'b0, E_NONE);
    step("final",        1'b0, 32'h0,        32'h0,   1'b1, 1'b0, E_NONE);
    n_assert++;
    assert (q.size() === 0) else begin
      n_fail++;
      $error("FAIL queue_empty obs=%0d exp=0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
